battleship_game_ctrl: RTL and testbench

Parametrised game controller for the Battleship lab. It replaces the fixed 5x5 hand-wired top-level logic with one block that owns both N x N boards, the cursor, the turn sequencing, a per-turn timeout and an LFSR-driven PC opponent. The PC opponent places its own ships and fires its own shots. Board outputs are flat vectors consumed by the VGA controller and the seven-segment driver.

---
 rtl/battleship_game_ctrl.sv | 150 +++++++++++++++
 tb/tb_battleship_game_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/battleship_game_ctrl.sv
`timescale 1ns/1ps
// battleship_game_ctrl: two-board NxN battleship FSM (cursor, turns, timeout, LFSR PC opponent); flat 3-bit/cell board outputs
module battleship_game_ctrl #(
  parameter int N = 5,
  parameter int BOATS_W = 3,
  parameter int MAX_BOATS = 5,
  parameter int TURN_CYCLES = 500000000,
  parameter int TIMER_W = 29,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 direction,
  input  logic                 move_h,
  input  logic                 move_v,
  input  logic                 fire,
  input  logic [BOATS_W-1:0]   amount_boats,
  output logic [3*N*N-1:0]     player_board,
  output logic [3*N*N-1:0]     pc_board_view,
  output logic [2:0]           cursor_row,
  output logic [2:0]           cursor_col,
  output logic [BOATS_W-1:0]   boats_left_player,
  output logic [BOATS_W-1:0]   boats_left_pc,
  output logic [2:0]           game_state,
  output logic                 hit,
  output logic                 time_expired,
  output logic                 win,
  output logic                 lose
);
  localparam int IW = $clog2(N * N);
  localparam logic [2:0] LAST = 3'(N - 1);
  localparam logic [BOATS_W-1:0] ONE = BOATS_W'(1);
  localparam logic [BOATS_W-1:0] MAXB = BOATS_W'(MAX_BOATS);
  localparam logic [TIMER_W-1:0] TLAST = TIMER_W'(TURN_CYCLES - 1);
  localparam logic [1:0] WATER = 2'd0, SHIP = 2'd1, HIT = 2'd2, MISS = 2'd3;
  typedef enum logic [2:0] {IDLE, PC_PLACE, PLAYER_PLACE, PLAYER_TURN, PC_TURN, WIN, LOSE} state_t;
  state_t state;
  logic [N*N-1:0][1:0] pb, pcb;
  logic [15:0] lfsr;
  logic [TIMER_W-1:0] timer;
  logic [BOATS_W-1:0] k;
  logic start_q, move_h_q, move_v_q, fire_q;
  logic start_e, move_h_e, move_v_e, fire_e, moving;
  logic [IW-1:0] cur, cand;
  assign start_e = start & ~start_q;
  assign move_h_e = move_h & ~move_h_q;
  assign move_v_e = move_v & ~move_v_q;
  assign fire_e = fire & ~fire_q;
  assign moving = state == PLAYER_PLACE || state == PLAYER_TURN;
  assign cur = IW'(int'(cursor_row) * N + int'(cursor_col));
  assign cand = IW'(int'(lfsr[7:0]) % N * N + int'(lfsr[15:8]) % N);
  assign game_state = state;
  function automatic logic [2:0] step(input logic [2:0] v, input logic d);
    return d ? (v == 3'd0 ? LAST : v - 3'd1) : (v == LAST ? 3'd0 : v + 3'd1);
  endfunction
  always_comb begin
    player_board = '0;
    pc_board_view = '0;
    for (int i = 0; i < N * N; i++) begin
      player_board[3*i +: 3] = {1'b0, pb[i]};
      pc_board_view[3*i +: 3] = {1'b0, pcb[i] == SHIP ? WATER : pcb[i]};
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      pb <= '0;
      pcb <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      boats_left_player <= '0;
      boats_left_pc <= '0;
      timer <= '0;
      lfsr <= LFSR_SEED;
      k <= ONE;
      hit <= 1'b0;
      time_expired <= 1'b0;
      win <= 1'b0;
      lose <= 1'b0;
      start_q <= 1'b0;
      move_h_q <= 1'b0;
      move_v_q <= 1'b0;
      fire_q <= 1'b0;
    end else begin
      start_q <= start;
      move_h_q <= move_h;
      move_v_q <= move_v;
      fire_q <= fire;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      hit <= 1'b0;
      time_expired <= 1'b0;
      win <= state == WIN;
      lose <= state == LOSE;
      if (moving && move_h_e) cursor_col <= step(cursor_col, direction);
      if (moving && move_v_e) cursor_row <= step(cursor_row, direction);
      case (state)
        IDLE, WIN, LOSE: if (start_e) begin
          pb <= '0;
          pcb <= '0;
          k <= amount_boats == '0 ? ONE : amount_boats > MAXB ? MAXB : amount_boats;
          boats_left_player <= '0;
          boats_left_pc <= '0;
          state <= PC_PLACE;
        end
        PC_PLACE: if (pcb[cand] == WATER) begin
          pcb[cand] <= SHIP;
          boats_left_pc <= boats_left_pc + ONE;
          if (boats_left_pc + ONE == k) state <= PLAYER_PLACE;
        end
        PLAYER_PLACE: if (fire_e && pb[cur] == WATER) begin
          pb[cur] <= SHIP;
          boats_left_player <= boats_left_player + ONE;
          if (boats_left_player + ONE == k) begin
            timer <= '0;
            state <= PLAYER_TURN;
          end
        end
        PLAYER_TURN: begin
          timer <= timer + 1'b1;
          // a valid shot in the timeout cycle wins over the timeout
          if (fire_e && pcb[cur] == SHIP) begin
            pcb[cur] <= HIT;
            boats_left_pc <= boats_left_pc - ONE;
            hit <= 1'b1;
            state <= boats_left_pc == ONE ? WIN : PC_TURN;
          end else if (fire_e && pcb[cur] == WATER) begin
            pcb[cur] <= MISS;
            state <= PC_TURN;
          end else if (timer == TLAST) begin
            time_expired <= 1'b1;
            state <= PC_TURN;
          end
        end
        PC_TURN: if (pb[cand] == SHIP) begin
          pb[cand] <= HIT;
          boats_left_player <= boats_left_player - ONE;
          hit <= 1'b1;
          timer <= '0;
          state <= boats_left_player == ONE ? LOSE : PLAYER_TURN;
        end else if (pb[cand] == WATER) begin
          pb[cand] <= MISS;
          timer <= '0;
          state <= PLAYER_TURN;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_battleship_game_ctrl.sv
`timescale 1ns/1ps
// tb_battleship_game_ctrl: directed game scenarios plus random play against a cycle-level game model
module tb_battleship_game_ctrl;
  localparam int N = 5, BW = 3, MAXB = 5, TC = 10, TW = 4;
  logic clock, reset, start, direction, move_h, move_v, fire;
  logic [BW-1:0] amount_boats;
  logic [3*N*N-1:0] player_board, pc_board_view;
  logic [2:0] cursor_row, cursor_col, game_state;
  logic [BW-1:0] boats_left_player, boats_left_pc;
  logic hit, time_expired, win, lose;
  int total = 0, bad = 0;
  int mp[N*N], mc[N*N];
  int ms, mrow, mcol, mbp, mbc, mk, mtimer;
  logic [15:0] mlfsr;
  bit ps, ph, pv, pf, mhit, mte, mwin, mlose;
  int n, ti, n3;

  battleship_game_ctrl #(.N(N), .BOATS_W(BW), .MAX_BOATS(MAXB), .TURN_CYCLES(TC), .TIMER_W(TW),
    .LFSR_SEED(16'hACE1)) dut (
    .clock(clock), .reset(reset), .start(start), .direction(direction), .move_h(move_h),
    .move_v(move_v), .fire(fire), .amount_boats(amount_boats), .player_board(player_board),
    .pc_board_view(pc_board_view), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .boats_left_player(boats_left_player), .boats_left_pc(boats_left_pc), .game_state(game_state),
    .hit(hit), .time_expired(time_expired), .win(win), .lose(lose));

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [127:0] flat(input bit pc);
    logic [127:0] v = '0;
    for (int i = 0; i < N * N; i++) v[3*i +: 3] = 3'(pc ? (mc[i] == 1 ? 0 : mc[i]) : mp[i]);
    return v;
  endfunction

  // game rules applied once per rising clock edge
  task automatic model_step();
    int cur, cand, os, t;
    bit se, he, ve, fe;
    if (!reset) begin
      for (int i = 0; i < N * N; i++) begin mp[i] = 0; mc[i] = 0; end
      ms = 0; mrow = 0; mcol = 0; mbp = 0; mbc = 0; mtimer = 0; mlfsr = 16'hACE1;
      mhit = 0; mte = 0; mwin = 0; mlose = 0; ps = 0; ph = 0; pv = 0; pf = 0;
      return;
    end
    se = start && !ps; he = move_h && !ph; ve = move_v && !pv; fe = fire && !pf;
    ps = start; ph = move_h; pv = move_v; pf = fire;
    cur = mrow * N + mcol;
    cand = (mlfsr[7:0] % N) * N + (mlfsr[15:8] % N);
    os = ms; mhit = 0; mte = 0; mwin = os == 5; mlose = os == 6;
    if (os == 0 || os == 5 || os == 6) begin
      if (se) begin
        for (int i = 0; i < N * N; i++) begin mp[i] = 0; mc[i] = 0; end
        mk = amount_boats == 0 ? 1 : (amount_boats > MAXB ? MAXB : int'(amount_boats));
        mbp = 0; mbc = 0; ms = 1;
      end
    end else if (os == 1) begin
      if (mc[cand] == 0) begin mc[cand] = 1; mbc++; if (mbc == mk) ms = 2; end
    end else if (os == 2) begin
      if (fe && mp[cur] == 0) begin
        mp[cur] = 1; mbp++;
        if (mbp == mk) begin mtimer = 0; ms = 3; end
      end
    end else if (os == 3) begin
      t = mtimer; mtimer++;
      if (fe && mc[cur] == 1) begin mc[cur] = 2; mbc--; mhit = 1; ms = mbc == 0 ? 5 : 4; end
      else if (fe && mc[cur] == 0) begin mc[cur] = 3; ms = 4; end
      else if (t == TC - 1) begin mte = 1; ms = 4; end
    end else if (os == 4) begin
      if (mp[cand] == 1) begin
        mp[cand] = 2; mbp--; mhit = 1;
        if (mbp == 0) ms = 6; else begin mtimer = 0; ms = 3; end
      end else if (mp[cand] == 0) begin mp[cand] = 3; mtimer = 0; ms = 3; end
    end
    if (os == 2 || os == 3) begin
      if (he) mcol = direction ? (mcol + N - 1) % N : (mcol + 1) % N;
      if (ve) mrow = direction ? (mrow + N - 1) % N : (mrow + 1) % N;
    end
    mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
  endtask

  task automatic compare_all();
    chk("game_state", game_state, ms);
    chk("player_board", player_board, flat(0));
    chk("pc_board_view", pc_board_view, flat(1));
    chk("cursor_row", cursor_row, mrow);
    chk("cursor_col", cursor_col, mcol);
    chk("boats_left_player", boats_left_player, mbp);
    chk("boats_left_pc", boats_left_pc, mbc);
    chk("hit", hit, mhit);
    chk("time_expired", time_expired, mte);
    chk("win", win, mwin);
    chk("lose", lose, mlose);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #2;
    compare_all();
    @(negedge clock);
  endtask

  task automatic wait_ms(input int s, input int lim, output int cnt);
    cnt = 0;
    while (ms != s && cnt < lim) begin tick(); cnt++; end
    chk("wait_state_reached", ms, s);
  endtask

  task automatic press_fire();
    fire = 1; tick(); fire = 0; tick();
  endtask

  function automatic int find_ship();
    for (int i = 0; i < N * N; i++) if (mc[i] == 1) return i;
    return 0;
  endfunction

  // steer the cursor, alternating axes so each step still sees a fresh rising edge
  task automatic goto(input int r, input int c);
    int ax = -1;
    int dr, dc;
    for (int i = 0; i < 12; i++) begin
      dr = (r - mrow + N) % N;
      dc = (c - mcol + N) % N;
      if (dr == 0 && dc == 0) break;
      move_h = 0; move_v = 0;
      if (dc != 0 && ax != 0) begin move_h = 1; direction = dc > N / 2; ax = 0; end
      else if (dr != 0 && ax != 1) begin move_v = 1; direction = dr > N / 2; ax = 1; end
      else ax = -1;
      tick();
    end
    move_h = 0; move_v = 0;
  endtask

  initial begin
    reset = 0; start = 0; direction = 0; move_h = 0; move_v = 0; fire = 0; amount_boats = 0;
    tick(); tick();
    reset = 1;
    tick();
    chk("rst_state", game_state, 0);
    chk("rst_player_board", player_board, 0);
    chk("rst_pc_board", pc_board_view, 0);
    chk("rst_cursor", {cursor_row, cursor_col}, 0);
    chk("rst_flags", {hit, win, lose, time_expired}, 0);
    // zero boats requested clamps to one
    start = 1; tick(); start = 0;
    wait_ms(2, 30, n);
    chk("k1_place_within_25", n <= 25, 1);
    chk("k1_state", game_state, 2);
    chk("k1_boats_pc", boats_left_pc, 1);
    direction = 1;
    for (int i = 0; i < 3; i++) begin move_h = 1; tick(); move_h = 0; tick(); end
    chk("wrap_col", cursor_col, 2);
    chk("wrap_row", cursor_row, 0);
    // three-ship game
    reset = 0; tick(); tick(); reset = 1;
    amount_boats = 3;
    start = 1; tick(); start = 0;
    wait_ms(2, 60, n);
    chk("k3_boats_pc", boats_left_pc, 3);
    direction = 0;
    press_fire();
    chk("place1", boats_left_player, 1);
    press_fire();
    chk("place_dup_count", boats_left_player, 1);
    chk("place_dup_board", player_board, 128'h1);
    move_h = 1; tick(); move_h = 0; tick();
    press_fire();
    move_v = 1; tick(); move_v = 0; tick();
    press_fire();
    chk("place_done_state", game_state, 3);
    chk("place_done_count", boats_left_player, 3);
    chk("place_done_board", player_board, 128'h40009);
    ti = find_ship();
    goto(ti / N, ti % N);
    fire = 1; tick();
    chk("hit1_pulse", hit, 1);
    chk("hit1_state", game_state, 4);
    chk("hit1_boats", boats_left_pc, 2);
    chk("hit1_cell", pc_board_view[3*ti +: 3], 2);
    fire = 0;
    wait_ms(3, 100, n);
    fire = 1; tick(); fire = 0;
    chk("dup_shot_state", game_state, 3);
    chk("dup_shot_boats", boats_left_pc, 2);
    chk("dup_shot_cell", pc_board_view[3*ti +: 3], 2);
    ti = find_ship();
    goto(ti / N, ti % N);
    fire = 1; tick(); fire = 0;
    chk("hit2_state", game_state, 4);
    chk("hit2_boats", boats_left_pc, 1);
    wait_ms(3, 100, n);
    ti = find_ship();
    goto(ti / N, ti % N);
    fire = 1; tick(); fire = 0;
    chk("hit3_state", game_state, 5);
    chk("hit3_boats", boats_left_pc, 0);
    tick();
    chk("win_flag", win, 1);
    // restart from WIN with an over-range request (clamps to five)
    amount_boats = 7;
    start = 1; tick(); start = 0;
    chk("restart_state", game_state, 1);
    chk("restart_player_board", player_board, 0);
    chk("restart_pc_board", pc_board_view, 0);
    wait_ms(2, 60, n);
    chk("k5_boats_pc", boats_left_pc, 5);
    n3 = 0;
    for (int i = 0; i < 300 && ms != 3; i++) begin
      direction = 1'($urandom); move_h = 1'($urandom); move_v = 1'($urandom); fire = 1'($urandom);
      tick();
      if (game_state == 3) n3++;
      move_h = 0; move_v = 0; fire = 0;
      tick();
      if (game_state == 3) n3++;
    end
    while (game_state == 3 && n3 < 20) begin
      tick();
      if (game_state == 3) n3++;
    end
    chk("timeout_turn_len", n3, 10);
    chk("timeout_pulse", time_expired, 1);
    chk("timeout_state", game_state, 4);
    chk("timeout_pc_board", pc_board_view, 0);
    reset = 0; tick();
    chk("reset_in_pc_turn", game_state, 0);
    reset = 1;
    // random play
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom % 400) != 0;
      start = ($urandom % 20) == 0;
      direction = 1'($urandom);
      move_h = ($urandom % 3) == 0;
      move_v = ($urandom % 3) == 0;
      fire = ($urandom % 3) == 0;
      amount_boats = BW'($urandom);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
